// File: rtl/edge_binarize.sv
// Purpose: thresholds unsigned gradient magnitudes into 1-bit edge pixels, with per-frame edge count.
// Latency: 1 cycle from input accept to valid_o; one pixel per cycle while ready_i is held high.
// Backpressure: single-entry output register; ready_o = ~valid_o | ready_i, so input stalls while output is held.
//
// Ports:
//   clk_i, rst_i            clock and synchronous active-high reset
//   valid_i, ready_o, mag_i input magnitude stream; threshold_i is sampled only on pixel (0,0)
//   valid_o, ready_i        binary pixel stream; data_o = edge bit, last_o = last pixel of frame
//   frame_done_o            one-cycle pulse after the last pixel of a frame is accepted
//   edge_count_o            number of 1-pixels in the most recently completed frame
module edge_binarize #(
  parameter int unsigned MagWidth    = 6,
  parameter int unsigned LineWidthPx = 318,
  parameter int unsigned LineCountPx = 238,
  parameter int unsigned CountWidth  = $clog2(LineWidthPx*LineCountPx+1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [MagWidth-1:0]   mag_i,
  input  logic [MagWidth-1:0]   threshold_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  data_o,
  output logic                  last_o,
  output logic                  frame_done_o,
  output logic [CountWidth-1:0] edge_count_o
);

  localparam int unsigned ColW = $clog2(LineWidthPx + 1);
  localparam int unsigned RowW = $clog2(LineCountPx + 1);

  logic                  valid_q, valid_d;
  logic                  data_q, data_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [CountWidth-1:0] acc_q, acc_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [MagWidth-1:0]   thr_q, thr_d;

  logic                  in_acc;
  logic                  out_acc;
  logic                  first_px;
  logic                  col_end;
  logic                  row_end;
  logic                  last_px;
  logic [MagWidth-1:0]   thr_eff;
  logic                  pix_bit;

  assign ready_o  = ~valid_q | ready_i;
  assign in_acc   = valid_i & ready_o;
  assign out_acc  = valid_q & ready_i;

  assign first_px = (col_q == '0) && (row_q == '0);
  assign col_end  = (col_q == ColW'(LineWidthPx - 1));
  assign row_end  = (row_q == RowW'(LineCountPx - 1));
  assign last_px  = col_end & row_end;

  // The first pixel of a frame uses the live threshold so the latch costs no
  // extra cycle; every later pixel uses the value captured with it.
  assign thr_eff  = first_px ? threshold_i : thr_q;
  assign pix_bit  = (mag_i >= thr_eff);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    count_d = count_q;
    acc_d   = acc_q;
    col_d   = col_q;
    row_d   = row_q;
    thr_d   = thr_q;

    if (out_acc) begin
      valid_d = 1'b0;
    end

    // An input accept in the same cycle as an output accept reloads the
    // register, so valid stays high.
    if (in_acc) begin
      valid_d = 1'b1;
      data_d  = pix_bit;
      last_d  = last_px;

      if (first_px) begin
        thr_d = threshold_i;
      end

      if (last_px) begin
        count_d = acc_q + CountWidth'(pix_bit);
        acc_d   = '0;
        done_d  = 1'b1;
      end else begin
        acc_d   = acc_q + CountWidth'(pix_bit);
      end

      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      acc_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      thr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      col_q   <= col_d;
      row_q   <= row_d;
      thr_q   <= thr_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign last_o       = last_q;
  assign frame_done_o = done_q;
  assign edge_count_o = count_q;

endmodule

// File: tb/tb_edge_binarize.sv
// Purpose: self-checking bench for edge_binarize on a 4x3 frame with 6-bit magnitudes.
// Latency: model expects each pixel on the output one cycle after its input accept.
// Backpressure: ready_i is dropped for a few cycles mid-frame; the model tracks the held output.
module tb_edge_binarize;

  localparam int MW = 6;
  localparam int LW = 4;
  localparam int LC = 3;
  localparam int CW = 4;
  localparam int NPX = LW * LC;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [MW-1:0] mag_i;
  logic [MW-1:0] threshold_i;
  logic          valid_o;
  logic          ready_i;
  logic          data_o;
  logic          last_o;
  logic          frame_done_o;
  logic [CW-1:0] edge_count_o;

  edge_binarize #(
    .MagWidth   (MW),
    .LineWidthPx(LW),
    .LineCountPx(LC),
    .CountWidth (CW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .mag_i       (mag_i),
    .threshold_i (threshold_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .last_o      (last_o),
    .frame_done_o(frame_done_o),
    .edge_count_o(edge_count_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a linear pixel index within the frame, the threshold
  // captured with pixel 0, a running sum of edge bits and the single held output.
  int m_valid = 0;
  int m_data  = 0;
  int m_last  = 0;
  int m_done  = 0;
  int m_count = 0;
  int m_idx   = 0;
  int m_sum   = 0;
  int m_thr   = 0;

  int done_seen    = 0;
  int out_in_frame = 0;
  int last_at      = 0;

  always @(negedge clk_i) begin
    int thr;
    int b;
    logic acc_in;
    logic acc_out;

    chk("valid_o",      32'(valid_o),      m_valid);
    chk("ready_o",      32'(ready_o),      32'(!m_valid || ready_i));
    chk("data_o",       32'(data_o),       m_data);
    chk("last_o",       32'(last_o),       m_last);
    chk("frame_done_o", 32'(frame_done_o), m_done);
    chk("edge_count_o", 32'(edge_count_o), m_count);

    if (frame_done_o === 1'b1) done_seen++;

    if (rst_i) begin
      out_in_frame = 0;
    end else if (valid_o === 1'b1 && ready_i) begin
      out_in_frame++;
      if (last_o === 1'b1) begin
        last_at = out_in_frame;
        out_in_frame = 0;
      end
    end

    // Advance the model to what the coming rising edge must produce.
    if (rst_i) begin
      m_valid = 0; m_data = 0; m_last = 0; m_done = 0;
      m_count = 0; m_idx = 0; m_sum = 0; m_thr = 0;
    end else begin
      acc_out = (m_valid != 0) && ready_i;
      acc_in  = valid_i && ((m_valid == 0) || ready_i);
      m_done  = 0;
      if (acc_out) m_valid = 0;
      if (acc_in) begin
        if (m_idx == 0) m_thr = int'(threshold_i);
        thr     = m_thr;
        b       = (int'(mag_i) >= thr) ? 1 : 0;
        m_valid = 1;
        m_data  = b;
        m_last  = (m_idx == NPX - 1) ? 1 : 0;
        m_sum  += b;
        if (m_idx == NPX - 1) begin
          m_count = m_sum;
          m_sum   = 0;
          m_done  = 1;
          m_idx   = 0;
        end else begin
          m_idx++;
        end
      end
    end
  end

  int stall_left = 0;

  // One clock step; inputs always change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    ready_i = (stall_left == 0);
    if (stall_left > 0) stall_left--;
  endtask

  task automatic send(input int mag, input int thr, input int gap);
    int n;
    logic ok;
    valid_i = 1'b0;
    for (int g = 0; g < gap; g++) begin
      mag_i = MW'($urandom);
      step();
    end
    valid_i     = 1'b1;
    mag_i       = MW'(mag);
    threshold_i = MW'(thr);
    n  = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk_i);
      ok = ready_o;
      step();
      n++;
      if (!ok && n > 50) begin
        errors++;
        checks++;
        $display("FAIL accept timeout: mag %0d not accepted after %0d cycles", mag, n);
        ok = 1'b1;
      end
    end
  endtask

  task automatic end_frame(input string tag, input int exp_cnt, input int exp_done);
    valid_i = 1'b0;
    step();
    step();
    @(negedge clk_i);
    chk({tag, " edge_count"}, 32'(edge_count_o), exp_cnt);
    chk({tag, " done pulses"}, done_seen, exp_done);
    chk({tag, " last position"}, last_at, NPX);
    last_at = 0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b1;
    valid_i     = 1'b1;
    ready_i     = 1'b1;
    mag_i       = MW'(20);
    threshold_i = MW'(3);

    // Reset held two cycles with valid_i asserted.
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("reset valid_o",      32'(valid_o),      0);
    chk("reset edge_count_o", 32'(edge_count_o), 0);
    chk("reset frame_done_o", 32'(frame_done_o), 0);
    @(posedge clk_i);
    #1;

    // Streaming: threshold 5, mags 0..11 -> 7 edge pixels.
    for (int i = 0; i < NPX; i++) send(i, 5, 0);
    end_frame("stream", 7, 1);

    // Backpressure: ready_i low for 3 cycles starting after pixel 6.
    for (int i = 0; i < NPX; i++) begin
      if (i == 6) stall_left = 3;
      send(i, 5, 0);
    end
    end_frame("backpressure", 7, 2);

    // Threshold latch: change to 0 at pixel 3 must not affect this frame.
    for (int i = 0; i < NPX; i++) send(i, (i < 3) ? 5 : 0, 0);
    end_frame("thr latch f1", 7, 3);
    for (int i = 0; i < NPX; i++) send(i, 0, 0);
    end_frame("thr latch f2", 12, 4);

    // Threshold above every magnitude used.
    for (int i = 0; i < NPX; i++) send(62, 63, 0);
    end_frame("thr 63", 0, 5);

    // Irregular gaps on valid_i.
    for (int i = 0; i < NPX; i++) send(i, 0, i % 3);
    end_frame("gaps thr 0", 12, 6);
    for (int i = 0; i < NPX; i++) send(i, 5, (i * 7) % 4);
    end_frame("gaps thr 5", 7, 7);

    // Mid-frame reset after 6 pixels; partial frame must be discarded.
    for (int i = 0; i < 6; i++) send(i + 20, 5, 0);
    valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("midreset edge_count_o", 32'(edge_count_o), 0);
    chk("midreset valid_o",      32'(valid_o),      0);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < NPX; i++) send(i, 5, 0);
    end_frame("after midreset", 7, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
